// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style interrupt acknowledge logic.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK1 = 2'd2
    } ack_state_e;

    localparam logic [2:0] SPURIOUS_LEVEL  = 3'd7;
    localparam logic [2:0] LOWEST_PRIO_RST = 3'd7;

    typedef struct packed {
        logic       found;
        logic [2:0] level;
    } ffs_result_t;

    // Highest-priority set bit of vec, where priority starts just above
    // 'lowest' and wraps. Rotating first lets a plain low-to-high priority
    // encoder do the search; the offset is added back afterwards.
    function automatic ffs_result_t rot_find_first(input logic [7:0] vec,
                                                   input logic [2:0] lowest);
        logic [2:0]  start;
        logic [7:0]  rot;
        ffs_result_t res;
        start = lowest + 3'd1;
        rot   = 8'({vec, vec} >> start);
        res   = '0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                res.found = 1'b1;
                res.level = start + 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pic_ack_sequencer_if.sv
// Bus between the controller core (register file, resolver) and the
// acknowledge sequencer.
interface pic_ack_sequencer_if #(parameter int VEC_BASE_W = 5);

    logic [7:0]            irr;
    logic [7:0]            imr;
    logic [2:0]            highest_priority_int;
    logic                  inta;
    logic [VEC_BASE_W-1:0] vector_base;
    logic                  aeoi;
    logic                  eoi;
    logic                  eoi_specific;
    logic [2:0]            eoi_level;
    logic                  rotate_on_eoi;

    logic                  int_out;
    logic [7:0]            isr;
    logic [7:0]            clr_irr;
    logic [2:0]            lowest_prio;
    logic [VEC_BASE_W+2:0] vector;
    logic                  vector_valid;

    modport master (
        output irr, imr, highest_priority_int, inta, vector_base, aeoi,
               eoi, eoi_specific, eoi_level, rotate_on_eoi,
        input  int_out, isr, clr_irr, lowest_prio, vector, vector_valid
    );

    modport slave (
        input  irr, imr, highest_priority_int, inta, vector_base, aeoi,
               eoi, eoi_specific, eoi_level, rotate_on_eoi,
        output int_out, isr, clr_irr, lowest_prio, vector, vector_valid
    );

endinterface

// File: rtl/pic_ack_sequencer_isr_eoi_unit.sv
// In-Service Register and rotating priority pointer. Takes set/clear
// requests from the acknowledge FSM and applies EOI commands.
module isr_eoi_unit
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en_i,
    input  logic [2:0] set_lvl_i,
    input  logic       aeoi_clr_en_i,
    input  logic [2:0] aeoi_clr_lvl_i,
    input  logic       eoi_i,
    input  logic       eoi_specific_i,
    input  logic [2:0] eoi_level_i,
    input  logic       rotate_i,
    output logic [7:0] isr_o,
    output logic [2:0] lowest_prio_o
);

    logic [7:0]  isr_q, isr_d;
    logic [2:0]  lowest_q, lowest_d;
    ffs_result_t ffs;
    logic        eoi_hit;
    logic [2:0]  eoi_lvl;
    logic [7:0]  eoi_mask, aeoi_mask, set_mask;

    // EOI is resolved against the current ISR; the FSM set is OR-ed in last
    // so it wins when both hit the same bit.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        ffs       = rot_find_first(isr_q, lowest_q);
        eoi_lvl   = eoi_specific_i ? eoi_level_i : ffs.level;
        eoi_hit   = eoi_i & (eoi_specific_i ? isr_q[eoi_level_i] : ffs.found);
        eoi_mask  = eoi_hit ? (8'd1 << eoi_lvl) : 8'd0;
        aeoi_mask = aeoi_clr_en_i ? (8'd1 << aeoi_clr_lvl_i) : 8'd0;
        set_mask  = set_en_i ? (8'd1 << set_lvl_i) : 8'd0;
        isr_d     = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
        lowest_d  = (eoi_hit & rotate_i) ? eoi_lvl : lowest_q;
    end

    // ISR and priority pointer registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            isr_q    <= 8'd0;
            lowest_q <= LOWEST_PRIO_RST;
        end else begin
            isr_q    <= isr_d;
            lowest_q <= lowest_d;
        end
    end

    assign isr_o         = isr_q;
    assign lowest_prio_o = lowest_q;

endmodule

// File: rtl/pic_ack_sequencer.sv
// Interrupt acknowledge sequencer: raises INT, runs the two-pulse INTA
// handshake and hands ISR/EOI bookkeeping to isr_eoi_unit.
module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter int VEC_BASE_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    pic_ack_sequencer_if.slave  bus
);

    ack_state_e            state_q, state_d;
    logic                  inta_q;
    logic                  inta_rise;
    logic                  req_valid;
    logic [2:0]            hpi;
    logic [7:0]            isr;
    logic [2:0]            lowest_prio;

    logic [2:0]            level_q, level_d;
    logic                  spurious_q, spurious_d;
    logic                  int_out_q, int_out_d;
    logic [7:0]            clr_irr_q, clr_irr_d;
    logic [VEC_BASE_W+2:0] vector_q, vector_d;
    logic                  vector_valid_q, vector_valid_d;
    logic                  isr_set_en;
    logic                  isr_clr_en;

    assign hpi       = bus.highest_priority_int;
    assign inta_rise = bus.inta & ~inta_q;
    assign req_valid = bus.irr[hpi] & ~bus.imr[hpi] & ~isr[hpi];

    // State, edge detector and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            inta_q         <= 1'b0;
            level_q        <= SPURIOUS_LEVEL;
            spurious_q     <= 1'b0;
            int_out_q      <= 1'b0;
            clr_irr_q      <= 8'd0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            inta_q         <= bus.inta;
            level_q        <= level_d;
            spurious_q     <= spurious_d;
            int_out_q      <= int_out_d;
            clr_irr_q      <= clr_irr_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
        end
    end

    // Next state: wait for a request, then two INTA edges.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_PEND;
            ST_PEND: if (inta_rise) state_d = ST_ACK1;
            ST_ACK1: if (inta_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and ISR requests; a request gone by the first INTA is spurious.
    always_comb begin
        int_out_d      = 1'b0;
        clr_irr_d      = 8'd0;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        level_d        = level_q;
        spurious_d     = spurious_q;
        isr_set_en     = 1'b0;
        isr_clr_en     = 1'b0;
        case (state_q)
            ST_PEND: begin
                int_out_d = ~inta_rise;
                if (inta_rise) begin
                    if (req_valid) begin
                        level_d    = hpi;
                        spurious_d = 1'b0;
                        isr_set_en = 1'b1;
                        clr_irr_d  = 8'd1 << hpi;
                    end else begin
                        level_d    = SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_rise) begin
                    vector_d       = {bus.vector_base, level_q};
                    vector_valid_d = 1'b1;
                    isr_clr_en     = bus.aeoi & ~spurious_q;
                end
            end
            default: ;
        endcase
    end

    isr_eoi_unit u_isr_eoi (
        .clk            (clk),
        .reset          (reset),
        .set_en_i       (isr_set_en),
        .set_lvl_i      (hpi),
        .aeoi_clr_en_i  (isr_clr_en),
        .aeoi_clr_lvl_i (level_q),
        .eoi_i          (bus.eoi),
        .eoi_specific_i (bus.eoi_specific),
        .eoi_level_i    (bus.eoi_level),
        .rotate_i       (bus.rotate_on_eoi),
        .isr_o          (isr),
        .lowest_prio_o  (lowest_prio)
    );

    assign bus.int_out      = int_out_q;
    assign bus.isr          = isr;
    assign bus.clr_irr      = clr_irr_q;
    assign bus.lowest_prio  = lowest_prio;
    assign bus.vector       = vector_q;
    assign bus.vector_valid = vector_valid_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Self-checking bench for pic_ack_sequencer: a table of complete
// acknowledge transactions, hand-written corner sequences, and a random
// mix of acknowledges and EOIs against a transaction-level model.
module tb_pic_ack_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pic_ack_sequencer_if #(.VEC_BASE_W(5)) bus();

    pic_ack_sequencer #(.VEC_BASE_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: which levels are in service, and the
    // current lowest-priority level.
    bit m_isr [8];
    int m_lowest;

    typedef struct {
        logic [7:0] irr;
        logic [7:0] imr;
        logic [2:0] hpi;
        logic [4:0] base;
        logic       aeoi;
        logic       spur;
        logic [7:0] exp_clr;
        logic [7:0] exp_isr1;
        logic [7:0] exp_vec;
        logic [7:0] exp_isr2;
    } ack_vec_t;

    ack_vec_t tbl [6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.irr                  = 8'd0;
        bus.imr                  = 8'd0;
        bus.highest_priority_int = 3'd0;
        bus.inta                 = 1'b0;
        bus.vector_base          = 5'd0;
        bus.aeoi                 = 1'b0;
        bus.eoi                  = 1'b0;
        bus.eoi_specific         = 1'b0;
        bus.eoi_level            = 3'd0;
        bus.rotate_on_eoi        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_int_out"}, 8'(bus.int_out), 8'd0);
        check({tag, "_isr"}, bus.isr, 8'd0);
        check({tag, "_clr_irr"}, bus.clr_irr, 8'd0);
        check({tag, "_lowest"}, 8'(bus.lowest_prio), 8'd7);
        check({tag, "_vector"}, bus.vector, 8'd0);
        check({tag, "_vvalid"}, 8'(bus.vector_valid), 8'd0);
    endtask

    // Bounded wait for INT; an expired bound is a failed comparison.
    task automatic wait_int(input string name);
        for (int i = 0; i < 8 && bus.int_out !== 1'b1; i++) step();
        check(name, 8'(bus.int_out), 8'd1);
    endtask

    // Full acknowledge of level l; returns what the second INTA produced.
    task automatic do_ack(input logic [2:0] l, input logic [4:0] base, input logic aeoi,
                          output logic [7:0] vec, output logic vvalid);
        bus.irr                  = 8'd1 << l;
        bus.imr                  = 8'd0;
        bus.highest_priority_int = l;
        bus.vector_base          = base;
        bus.aeoi                 = aeoi;
        wait_int("ack_int_rise");
        bus.inta = 1'b1; step();
        bus.inta = 1'b0; bus.irr = 8'd0; step();
        bus.inta = 1'b1; step();
        vec    = bus.vector;
        vvalid = bus.vector_valid;
        bus.inta = 1'b0; step();
    endtask

    task automatic do_eoi(input logic spec, input logic [2:0] lvl, input logic rot);
        bus.eoi = 1'b1; bus.eoi_specific = spec; bus.eoi_level = lvl; bus.rotate_on_eoi = rot;
        step();
        bus.eoi = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = 3'd0; bus.rotate_on_eoi = 1'b0;
    endtask

    function automatic logic [7:0] model_isr();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = m_isr[i];
        return r;
    endfunction

    task automatic model_eoi(input bit spec, input int lvl, input bit rot);
        int cleared;
        cleared = -1;
        if (spec) begin
            if (m_isr[lvl]) cleared = lvl;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                if (cleared < 0 && m_isr[(m_lowest + k) % 8]) cleared = (m_lowest + k) % 8;
            end
        end
        if (cleared >= 0) begin
            m_isr[cleared] = 1'b0;
            if (rot) m_lowest = cleared;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        logic       vv;

        tbl[0] = '{irr:8'h04, imr:8'h00, hpi:3'd2, base:5'h08, aeoi:1'b0, spur:1'b0,
                   exp_clr:8'h04, exp_isr1:8'h04, exp_vec:8'h42, exp_isr2:8'h04};
        tbl[1] = '{irr:8'h04, imr:8'h00, hpi:3'd2, base:5'h08, aeoi:1'b1, spur:1'b0,
                   exp_clr:8'h04, exp_isr1:8'h04, exp_vec:8'h42, exp_isr2:8'h00};
        tbl[2] = '{irr:8'h80, imr:8'h7F, hpi:3'd7, base:5'h1F, aeoi:1'b0, spur:1'b0,
                   exp_clr:8'h80, exp_isr1:8'h80, exp_vec:8'hFF, exp_isr2:8'h80};
        tbl[3] = '{irr:8'h10, imr:8'h00, hpi:3'd4, base:5'h03, aeoi:1'b0, spur:1'b1,
                   exp_clr:8'h00, exp_isr1:8'h00, exp_vec:8'h1F, exp_isr2:8'h00};
        tbl[4] = '{irr:8'h01, imr:8'h00, hpi:3'd0, base:5'h15, aeoi:1'b1, spur:1'b1,
                   exp_clr:8'h00, exp_isr1:8'h00, exp_vec:8'hAF, exp_isr2:8'h00};
        tbl[5] = '{irr:8'h01, imr:8'hFE, hpi:3'd0, base:5'h00, aeoi:1'b1, spur:1'b0,
                   exp_clr:8'h01, exp_isr1:8'h01, exp_vec:8'h00, exp_isr2:8'h00};

        // Reset state.
        do_reset();
        check_reset_values("rst");

        // Table of complete acknowledge transactions, each from reset.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            bus.irr                  = tbl[r].irr;
            bus.imr                  = tbl[r].imr;
            bus.highest_priority_int = tbl[r].hpi;
            bus.vector_base          = tbl[r].base;
            bus.aeoi                 = tbl[r].aeoi;
            step();
            check("tbl_int_early", 8'(bus.int_out), 8'd0);
            step();
            check("tbl_int_rise", 8'(bus.int_out), 8'd1);
            if (tbl[r].spur) bus.irr = 8'd0;
            bus.inta = 1'b1; step();
            check("tbl_clr_irr", bus.clr_irr, tbl[r].exp_clr);
            check("tbl_isr1", bus.isr, tbl[r].exp_isr1);
            check("tbl_int_fall", 8'(bus.int_out), 8'd0);
            bus.inta = 1'b0; bus.irr = 8'd0; step();
            check("tbl_clr_pulse", bus.clr_irr, 8'd0);
            check("tbl_vvalid_early", 8'(bus.vector_valid), 8'd0);
            bus.inta = 1'b1; step();
            check("tbl_vvalid", 8'(bus.vector_valid), 8'd1);
            check("tbl_vector", bus.vector, tbl[r].exp_vec);
            check("tbl_isr2", bus.isr, tbl[r].exp_isr2);
            bus.inta = 1'b0; step();
            check("tbl_vvalid_pulse", 8'(bus.vector_valid), 8'd0);
            check("tbl_vector_hold", bus.vector, tbl[r].exp_vec);
        end

        // Non-specific EOI walking the rotated priority order.
        do_reset();
        do_ack(3'd2, 5'h08, 1'b0, v, vv);
        do_ack(3'd0, 5'h08, 1'b0, v, vv);
        check("ns_isr_init", bus.isr, 8'h05);
        do_eoi(1'b0, 3'd0, 1'b0);
        check("ns_isr_a", bus.isr, 8'h04);
        check("ns_lowest_a", 8'(bus.lowest_prio), 8'd7);
        do_eoi(1'b0, 3'd0, 1'b1);
        check("ns_isr_b", bus.isr, 8'h00);
        check("ns_lowest_b", 8'(bus.lowest_prio), 8'd2);
        do_eoi(1'b0, 3'd0, 1'b1);
        check("ns_empty_lowest", 8'(bus.lowest_prio), 8'd2);
        do_eoi(1'b1, 3'd5, 1'b1);
        check("sp_unset_lowest", 8'(bus.lowest_prio), 8'd2);

        // Specific EOI in the same cycle as the first INTA.
        do_reset();
        do_ack(3'd1, 5'h04, 1'b0, v, vv);
        do_ack(3'd3, 5'h04, 1'b0, v, vv);
        check("co_isr_init", bus.isr, 8'h0A);
        bus.irr = 8'h01; bus.highest_priority_int = 3'd0;
        wait_int("co_int");
        bus.inta = 1'b1; bus.eoi = 1'b1; bus.eoi_specific = 1'b1; bus.eoi_level = 3'd3;
        step();
        bus.eoi = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = 3'd0;
        check("co_isr", bus.isr, 8'h03);
        check("co_clr", bus.clr_irr, 8'h01);
        bus.inta = 1'b0; bus.irr = 8'd0; step();
        bus.inta = 1'b1; step();
        check("co_vector", bus.vector, 8'h20);
        bus.inta = 1'b0; step();

        // Masked request and INTA edges in IDLE are both ignored; a held
        // INTA level counts as a single edge.
        do_reset();
        bus.irr = 8'h08; bus.imr = 8'h08; bus.highest_priority_int = 3'd3; bus.vector_base = 5'h02;
        bus.inta = 1'b1; step();
        bus.inta = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mask_int", 8'(bus.int_out), 8'd0);
        check("mask_vvalid", 8'(bus.vector_valid), 8'd0);
        check("mask_isr", bus.isr, 8'h00);
        bus.imr = 8'h00;
        wait_int("unmask_int");
        bus.inta = 1'b1; step();
        check("hold_isr", bus.isr, 8'h08);
        bus.irr = 8'd0;
        step(); step();
        check("hold_vvalid", 8'(bus.vector_valid), 8'd0);
        bus.inta = 1'b0; step();
        check("hold_vvalid2", 8'(bus.vector_valid), 8'd0);
        bus.inta = 1'b1; step();
        check("hold_vvalid3", 8'(bus.vector_valid), 8'd1);
        check("hold_vector", bus.vector, 8'h13);
        bus.inta = 1'b0; step();

        // Reset in ACK1, then a fresh acknowledge.
        do_reset();
        bus.irr = 8'h04; bus.highest_priority_int = 3'd2; bus.vector_base = 5'h08;
        wait_int("mid_int");
        bus.inta = 1'b1; step();
        bus.inta = 1'b0; bus.irr = 8'd0; step();
        check("mid_isr_pre", bus.isr, 8'h04);
        reset = 1'b1; step();
        reset = 1'b0;
        check_reset_values("mid");
        bus.inta = 1'b1; step();
        check("mid_no_vec_a", 8'(bus.vector_valid), 8'd0);
        bus.inta = 1'b0; step();
        check("mid_no_vec_b", 8'(bus.vector_valid), 8'd0);
        do_ack(3'd5, 5'h1A, 1'b0, v, vv);
        check("fresh_vvalid", 8'(vv), 8'd1);
        check("fresh_vector", v, 8'hD5);
        check("fresh_isr", bus.isr, 8'h20);

        // Random acknowledges and EOIs against the model.
        do_reset();
        for (int i = 0; i < 8; i++) m_isr[i] = 1'b0;
        m_lowest = 7;
        for (int it = 0; it < 80; it++) begin
            int free_lv [$];
            free_lv.delete();
            for (int i = 0; i < 8; i++) if (!m_isr[i]) free_lv.push_back(i);
            if (free_lv.size() > 0 && $urandom_range(0, 1) == 0) begin
                int         l;
                bit         spur, aeoi, co, co_spec, co_rot;
                int         co_lvl;
                logic [4:0] base;
                logic [7:0] exp_vec;
                l       = free_lv[$urandom_range(0, free_lv.size() - 1)];
                spur    = ($urandom_range(0, 4) == 0);
                aeoi    = $urandom_range(0, 1) == 1;
                co      = ($urandom_range(0, 3) == 0);
                co_spec = $urandom_range(0, 1) == 1;
                co_rot  = $urandom_range(0, 1) == 1;
                co_lvl  = $urandom_range(0, 7);
                base    = 5'($urandom);
                bus.irr                  = 8'($urandom) | (8'd1 << l);
                bus.imr                  = 8'($urandom) & ~(8'd1 << l);
                bus.highest_priority_int = 3'(l);
                bus.vector_base          = base;
                bus.aeoi                 = aeoi;
                wait_int("rnd_int");
                if (spur) bus.irr = bus.irr & ~(8'd1 << l);
                bus.inta = 1'b1;
                if (co) begin
                    bus.eoi = 1'b1; bus.eoi_specific = co_spec;
                    bus.eoi_level = 3'(co_lvl); bus.rotate_on_eoi = co_rot;
                    model_eoi(co_spec, co_lvl, co_rot);
                end
                if (!spur) m_isr[l] = 1'b1;
                step();
                check("rnd_clr", bus.clr_irr, spur ? 8'd0 : (8'd1 << l));
                check("rnd_isr1", bus.isr, model_isr());
                check("rnd_lowest1", 8'(bus.lowest_prio), 8'(m_lowest));
                bus.inta = 1'b0; bus.irr = 8'd0;
                bus.eoi = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = 3'd0; bus.rotate_on_eoi = 1'b0;
                step();
                check("rnd_clr_pulse", bus.clr_irr, 8'd0);
                bus.inta = 1'b1; step();
                exp_vec = {base, spur ? 3'd7 : 3'(l)};
                if (aeoi && !spur) m_isr[l] = 1'b0;
                check("rnd_vvalid", 8'(bus.vector_valid), 8'd1);
                check("rnd_vector", bus.vector, exp_vec);
                check("rnd_isr2", bus.isr, model_isr());
                bus.inta = 1'b0; step();
                check("rnd_vvalid_pulse", 8'(bus.vector_valid), 8'd0);
            end else begin
                bit spec, rot;
                int lvl;
                spec = $urandom_range(0, 1) == 1;
                rot  = $urandom_range(0, 1) == 1;
                lvl  = $urandom_range(0, 7);
                model_eoi(spec, lvl, rot);
                do_eoi(spec, 3'(lvl), rot);
                check("rnd_eoi_isr", bus.isr, model_isr());
                check("rnd_eoi_lowest", 8'(bus.lowest_prio), 8'(m_lowest));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
